// File: rtl/sram_d_arbiter.sv
// rtl/sram_d_arbiter.sv - two-master OBI arbiter for the scratchpad RAM data port
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin ties; fixed m0 priority otherwise)
module sram_d_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  input  logic                s_gnt_i,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                proto_err_o
);

  // Winner of this cycle's arbitration: 0 = m0, 1 = m1.
  logic w_sel_m1;
  // A request is accepted by the RAM this cycle.
  logic w_accept;
  // The response register holds a read, so RAM data must arrive now.
  logic w_rd_pending;
  // Response-protocol violation observed this cycle.
  logic w_err;

  // Response register: one outstanding transaction, returned the next cycle.
  logic r_rsp_valid;
  logic r_rsp_id;
  logic r_rsp_we;
  logic r_proto_err;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Most recent winner. Resets to m1 so that the first tie after reset goes to m0.
  logic r_last;

  // Round-robin pick: on a tie the master that did not win last time wins.
  always_comb begin
    w_sel_m1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      w_sel_m1 = ~r_last;
    end else begin
      w_sel_m1 = m1_req_i;
    end
  end

  // Pointer advances only when the RAM actually accepts a request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_sel_m1;
    end
  end
`else
  // Fixed priority pick: m1 wins only while m0 is idle.
  always_comb begin
    w_sel_m1 = 1'b0;
    w_sel_m1 = m1_req_i & ~m0_req_i;
  end
`endif

  // Request path: forward the winner's fields and steer the RAM grant back to it.
  always_comb begin
    s_req_o   = m0_req_i | m1_req_i;
    s_addr_o  = w_sel_m1 ? m1_addr_i  : m0_addr_i;
    s_we_o    = w_sel_m1 ? m1_we_i    : m0_we_i;
    s_be_o    = w_sel_m1 ? m1_be_i    : m0_be_i;
    s_wdata_o = w_sel_m1 ? m1_wdata_i : m0_wdata_i;
    m0_gnt_o  = m0_req_i & ~w_sel_m1 & s_gnt_i;
    m1_gnt_o  = m1_req_i &  w_sel_m1 & s_gnt_i;
    w_accept  = s_req_o & s_gnt_i;
  end

  // Capture who was granted and whether it was a write; the response leaves next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_id <= w_sel_m1;
        r_rsp_we <= s_we_o;
      end
    end
  end

  // Response path: rvalid to the owner only; read data passes through, writes return zero.
  always_comb begin
    m0_rvalid_o = r_rsp_valid & ~r_rsp_id;
    m1_rvalid_o = r_rsp_valid &  r_rsp_id;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    if (r_rsp_valid && !r_rsp_we) begin
      if (r_rsp_id) begin
        m1_rdata_o = s_rdata_i;
      end else begin
        m0_rdata_o = s_rdata_i;
      end
    end
  end

  // RAM rvalid must coincide exactly with a read response slot.
  always_comb begin
    w_rd_pending = r_rsp_valid & ~r_rsp_we;
    w_err        = (w_rd_pending & ~s_rvalid_i) | (s_rvalid_i & ~w_rd_pending);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_proto_err <= 1'b0;
    end else if (w_err) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_sram_d_arbiter.sv
// tb/tb_sram_d_arbiter.sv - scoreboard bench for sram_d_arbiter with a stub RAM
module tb_sram_d_arbiter;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i = 0, m1_req_i = 0;
  logic        m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i = 0, m1_addr_i = 0;
  logic        m0_we_i = 0, m1_we_i = 0;
  logic [3:0]  m0_be_i = 4'hF, m1_be_i = 4'hF;
  logic [31:0] m0_wdata_i = 0, m1_wdata_i = 0;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o;
  logic        s_gnt_i = 1'b1;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_rvalid_i = 1'b0;
  logic [31:0] s_rdata_i = 32'h0;
  logic        proto_err_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  sram_d_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  // Stub RAM: 16 words indexed by addr[5:2], read data one cycle after acceptance.
  logic [31:0] mem [16];
  logic        withhold = 1'b0;
  logic        ram_v, ram_we;
  logic [3:0]  ram_idx;
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;

  always @(posedge clk) begin
    ram_v   = s_req_o & s_gnt_i;
    ram_we  = s_we_o;
    ram_idx = s_addr_o[5:2];
    if (ram_v && ram_we) mem[ram_idx] = s_wdata_o;
    #1;
    s_rvalid_i = ram_v & ~ram_we & ~withhold;
    s_rdata_i  = (ram_v && !ram_we && !withhold) ? mem[ram_idx] : 32'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever either master sees rvalid.
  always @(negedge clk) begin
    rsp_t e;
    if (m0_rvalid_o || m1_rvalid_o) begin
      check("rvalid_onehot", {m0_rvalid_o, m1_rvalid_o} == 2'b11, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", m1_rvalid_o, e.id);
        check("rsp_rdata", e.id ? m1_rdata_o : m0_rdata_o, e.data);
        check("rsp_other_rdata", e.id ? m0_rdata_o : m1_rdata_o, 32'h0);
      end
    end else begin
      check("idle_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
    end
  end

  task automatic apply(input logic r0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic sg);
    @(posedge clk); #1;
    m0_req_i = r0; m0_we_i = we0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = we1; m1_addr_i = a1; m1_wdata_i = d1;
    s_gnt_i = sg;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic expect_gnt(input string name, input logic e0, input logic e1,
                            input logic push, input logic [31:0] data);
    rsp_t r;
    check(name, {m0_gnt_o, m1_gnt_o}, {e0, e1});
    if (push && (e0 || e1)) begin
      r.id = e1;
      r.data = data;
      exp_q.push_back(r);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    m0_req_i = 0; m1_req_i = 0; rst_ni = 1'b0;
    @(negedge clk);
    check("reset_outputs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, proto_err_o,
                            m0_rdata_o, m1_rdata_o}, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, proto_err_o, s_req_o}, 6'h0);
    check("reset_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // m0 only: write then read back.
    apply(1, 1, 32'h8000_0010, 32'hA5A5_5A5A, 0, 0, 0, 0, 1);
    expect_gnt("t1_wr_gnt", 1, 0, 1, 32'h0);
    apply(1, 0, 32'h8000_0010, 32'h0, 0, 0, 0, 0, 1);
    expect_gnt("t1_rd_gnt", 1, 0, 1, 32'hA5A5_5A5A);
    idle();
    idle();

    // Both masters read continuously for 4 cycles from a fresh pointer.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 32'h8000_0010, 0, 1, 0, 32'h8000_0020, 0, 1);
      if (RR && i[0]) expect_gnt("t2_gnt", 0, 1, 1, 32'hC0DE_0008);
      else            expect_gnt("t2_gnt", 1, 0, 1, 32'hA5A5_5A5A);
    end
    idle();
    idle();

    // RAM stalls for 3 cycles with both pending; first grant after goes to m0.
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 32'h8000_0010, 0, 1, 0, 32'h8000_0020, 0, 0);
      expect_gnt("t3_stall_gnt", 0, 0, 0, 32'h0);
      check("t3_stall_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
    end
    apply(1, 0, 32'h8000_0010, 0, 1, 0, 32'h8000_0020, 0, 1);
    expect_gnt("t3_first_gnt", 1, 0, 1, 32'hA5A5_5A5A);
    idle();
    idle();

    // Alternating m0 write / m1 read of the just-written word.
    apply(1, 1, 32'h8000_0030, 32'h1234_5678, 0, 0, 0, 0, 1);
    expect_gnt("t4_wr0", 1, 0, 1, 32'h0);
    apply(0, 0, 0, 0, 1, 0, 32'h8000_0030, 0, 1);
    expect_gnt("t4_rd0", 0, 1, 1, 32'h1234_5678);
    apply(1, 1, 32'h8000_0034, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
    expect_gnt("t4_wr1", 1, 0, 1, 32'h0);
    apply(0, 0, 0, 0, 1, 0, 32'h8000_0034, 0, 1);
    expect_gnt("t4_rd1", 0, 1, 1, 32'hDEAD_BEEF);
    idle();
    idle();
    check("t4_proto_err", proto_err_o, 1'b0);

    // RAM withholds read data: sticky error until reset.
    withhold = 1'b1;
    apply(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 1);
    expect_gnt("t5_gnt", 1, 0, 1, 32'h0);
    idle();
    check("t5_err_before", proto_err_o, 1'b0);
    withhold = 1'b0;
    idle();
    check("t5_err_set", proto_err_o, 1'b1);
    repeat (3) idle();
    check("t5_err_sticky", proto_err_o, 1'b1);
    pulse_reset();
    idle();
    check("t5_err_cleared", proto_err_o, 1'b0);

    // Reset pulsed in the cycle after a read grant drops the response.
    apply(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 1);
    expect_gnt("t6_gnt", 1, 0, 0, 32'h0);
    pulse_reset();
    @(negedge clk);
    check("t6_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
    idle();
    idle();
    check("t6_proto_err", proto_err_o, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
